// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU host: XIF request/response structs,
// memory responder states and the latched issue outcome used for commit.
package fir_xifu_pkg;
  localparam int         X_ID_WIDTH = 4;
  localparam logic [1:0] PRIV_M     = 2'b11;

  typedef logic [X_ID_WIDTH-1:0] xid_t;

  typedef struct packed {
    logic [31:0]      instr;
    logic [1:0]       mode;
    xid_t             id;
    logic [1:0][31:0] rs;
    logic [1:0]       rs_valid;
    logic [5:0]       ecs;
    logic             ecs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    xid_t id;
    logic commit_kill;
  } x_commit_t;

  typedef struct packed {
    xid_t        id;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    xid_t        id;
    logic [31:0] rdata;
    logic        err;
    logic        dbg;
  } x_mem_result_t;

  typedef struct packed {
    xid_t        id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
  } x_result_t;

  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_WAIT, MEM_RESP} mem_state_e;

  typedef struct packed {
    xid_t id;
    logic accept;
  } commit_lat_t;
endpackage

// File: rtl/cv32e40x_if_xif.sv
// CV-XIF link bundle; cpu_* modports face the host, coproc_* the coprocessor.
interface cv32e40x_if_xif;
  import fir_xifu_pkg::*;

  logic          issue_valid;
  logic          issue_ready;
  x_issue_req_t  issue_req;
  x_issue_resp_t issue_resp;

  logic          commit_valid;
  x_commit_t     commit;

  logic          mem_valid;
  logic          mem_ready;
  x_mem_req_t    mem_req;
  x_mem_resp_t   mem_resp;

  logic          mem_result_valid;
  x_mem_result_t mem_result;

  logic          result_valid;
  logic          result_ready;
  x_result_t     result;

  modport cpu_issue      (output issue_valid, issue_req, input issue_ready, issue_resp);
  modport cpu_commit     (output commit_valid, commit);
  modport cpu_mem        (input mem_valid, mem_req, output mem_ready, mem_resp);
  modport cpu_mem_result (output mem_result_valid, mem_result);
  modport cpu_result     (input result_valid, result, output result_ready);

  modport coproc_issue      (input issue_valid, issue_req, output issue_ready, issue_resp);
  modport coproc_commit     (input commit_valid, commit);
  modport coproc_mem        (output mem_valid, mem_req, input mem_ready, mem_resp);
  modport coproc_mem_result (input mem_result_valid, mem_result);
  modport coproc_result     (output result_valid, result, input result_ready);
endinterface

// File: rtl/fir_xifu_host_mem.sv
// Serves one coprocessor memory request at a time over a req/gnt/rvalid port
// and returns exactly one memory result per request.
module fir_xifu_host_mem
  import fir_xifu_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  cv32e40x_if_xif.cpu_mem               xif_mem_i,
  cv32e40x_if_xif.cpu_mem_result        xif_mem_result_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [31:0]                   mem_addr_o,
  output logic                          mem_we_o,
  output logic [3:0]                    mem_be_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic                          mem_rvalid_i,
  input  logic [31:0]                   mem_rdata_i
);
  mem_state_e r_state, w_next;
  x_mem_req_t r_req;
  logic [31:0] r_rdata;
  logic w_ready, w_req, w_res_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= MEM_IDLE;
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == MEM_IDLE && xif_mem_i.mem_valid) r_req   <= xif_mem_i.mem_req;
      if (r_state == MEM_WAIT && mem_rvalid_i)        r_rdata <= mem_rdata_i;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_req       = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        w_ready = rst_ni;
        if (xif_mem_i.mem_valid) w_next = MEM_REQ;
      end
      MEM_REQ: begin
        w_req = 1'b1;
        if (mem_gnt_i) w_next = MEM_WAIT;
      end
      MEM_WAIT: if (mem_rvalid_i) w_next = MEM_RESP;
      MEM_RESP: begin
        w_res_valid = 1'b1;
        w_next      = MEM_IDLE;
      end
      default: w_next = MEM_IDLE;
    endcase
  end

  assign xif_mem_i.mem_ready = w_ready;
  assign xif_mem_i.mem_resp  = '0;

  assign mem_req_o   = w_req;
  assign mem_addr_o  = r_req.addr;
  assign mem_we_o    = r_req.we;
  assign mem_be_o    = r_req.be;
  assign mem_wdata_o = r_req.wdata;

  // Stores return zero data; the bus may put anything on rdata for them.
  assign xif_mem_result_o.mem_result_valid = w_res_valid;
  assign xif_mem_result_o.mem_result = '{id:    r_req.id,
                                         rdata: r_req.we ? 32'h0 : r_rdata,
                                         err:   1'b0,
                                         dbg:   1'b0};
endmodule

// File: rtl/fir_xifu_host.sv
// Host end of CV-XIF: issues an instruction stream, commits one cycle later,
// tracks outstanding results and reports writebacks/exceptions.
module fir_xifu_host
  import fir_xifu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  input  logic [31:0]                   instr_i,
  input  logic [31:0]                   rs1_i,
  input  logic [31:0]                   rs2_i,
  input  logic                          kill_i,
  cv32e40x_if_xif.cpu_issue             xif_issue_o,
  cv32e40x_if_xif.cpu_commit            xif_commit_o,
  cv32e40x_if_xif.cpu_mem               xif_mem_i,
  cv32e40x_if_xif.cpu_mem_result        xif_mem_result_o,
  cv32e40x_if_xif.cpu_result            xif_result_i,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [31:0]                   mem_addr_o,
  output logic                          mem_we_o,
  output logic [3:0]                    mem_be_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic                          mem_rvalid_i,
  input  logic [31:0]                   mem_rdata_i,
  output logic                          wb_valid_o,
  output logic [4:0]                    wb_rd_o,
  output logic [31:0]                   wb_data_o,
  output logic                          illegal_o,
  output logic                          exc_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  xid_t        r_id;
  commit_lat_t r_commit;
  logic        r_commit_pending;
  logic [CW-1:0] r_outstanding;
  logic        r_wb_valid, r_exc;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        w_issue_valid, w_issue_hs, w_kill, w_inc, w_dec, w_res_hs;
  logic        w_unused;

  assign w_issue_valid = rst_ni && instr_valid_i && !r_commit_pending &&
                         (r_outstanding < CW'(MAX_OUTSTANDING));
  assign w_issue_hs    = w_issue_valid && xif_issue_o.issue_ready;
  assign instr_ready_o = w_issue_hs;

  assign xif_issue_o.issue_valid = w_issue_valid;
  assign xif_issue_o.issue_req   = '{instr:     instr_i,
                                     mode:      PRIV_M,
                                     id:        r_id,
                                     rs:        {rs2_i, rs1_i},
                                     rs_valid:  2'b11,
                                     ecs:       6'h0,
                                     ecs_valid: 1'b1};

  // A rejected instruction is always killed at commit.
  assign w_kill    = kill_i || !r_commit.accept;
  assign xif_commit_o.commit_valid = r_commit_pending;
  assign xif_commit_o.commit = '{id: r_commit.id, commit_kill: r_commit_pending && w_kill};
  assign illegal_o = r_commit_pending && !r_commit.accept;

  assign xif_result_i.result_ready = rst_ni;
  assign w_res_hs = xif_result_i.result_valid;
  assign w_inc    = r_commit_pending && !w_kill;
  assign w_dec    = w_res_hs && (r_outstanding != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id             <= '0;
      r_commit         <= '0;
      r_commit_pending <= 1'b0;
      r_outstanding    <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_rd          <= '0;
      r_wb_data        <= '0;
      r_exc            <= 1'b0;
    end else begin
      r_commit_pending <= w_issue_hs;
      if (w_issue_hs) begin
        r_id     <= r_id + xid_t'(1);
        r_commit <= '{id: r_id, accept: xif_issue_o.issue_resp.accept};
      end
      if (w_inc && !w_dec)      r_outstanding <= r_outstanding + CW'(1);
      else if (w_dec && !w_inc) r_outstanding <= r_outstanding - CW'(1);
      r_wb_valid <= w_res_hs && xif_result_i.result.we;
      if (w_res_hs && xif_result_i.result.we) begin
        r_wb_rd   <= xif_result_i.result.rd;
        r_wb_data <= xif_result_i.result.data;
      end
      r_exc <= w_res_hs && xif_result_i.result.exc;
    end
  end

  assign wb_valid_o = r_wb_valid;
  assign wb_rd_o    = r_wb_rd;
  assign wb_data_o  = r_wb_data;
  assign exc_o      = r_exc;

  assign w_unused = ^{xif_issue_o.issue_resp.writeback, xif_issue_o.issue_resp.loadstore,
                      xif_issue_o.issue_resp.exc, xif_result_i.result.id,
                      xif_result_i.result.exccode};

  fir_xifu_host_mem u_mem (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .xif_mem_i        (xif_mem_i),
    .xif_mem_result_o (xif_mem_result_o),
    .mem_req_o        (mem_req_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i)
  );
endmodule

// File: tb/tb_fir_xifu_host.sv
// Scoreboard bench for fir_xifu_host: stimulus pushes expectations, negedge
// monitors pop and compare commits, writebacks, exceptions and memory traffic.
module tb_fir_xifu_host;
  import fir_xifu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        instr_valid, instr_ready, kill;
  logic [31:0] instr, rs1, rs2;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, illegal, exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  cv32e40x_if_xif xif();

  fir_xifu_host #(.MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
    .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill),
    .xif_issue_o(xif), .xif_commit_o(xif), .xif_mem_i(xif),
    .xif_mem_result_o(xif), .xif_result_i(xif),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .illegal_o(illegal), .exc_o(exc)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { xid_t id; logic kill; logic ill; } ecommit_t;
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ewb_t;
  typedef struct packed { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } eport_t;
  typedef struct packed { xid_t id; logic [31:0] rdata; } emres_t;

  ecommit_t q_commit[$];
  ewb_t     q_wb[$];
  bit       q_exc[$];
  eport_t   q_port[$];
  emres_t   q_mres[$];

  ecommit_t m_c;
  ewb_t     m_w;
  eport_t   m_p;
  emres_t   m_r;
  bit       m_e;

  // Monitors: compare whatever the DUT presents against the queued expectation
  always @(negedge clk) if (rst_n) begin
    if (xif.commit_valid) begin
      if (q_commit.size() == 0) check("commit_unexpected", xif.commit_valid, 0);
      else begin
        m_c = q_commit.pop_front();
        check("commit_id", xif.commit.id, m_c.id);
        check("commit_kill", xif.commit.commit_kill, m_c.kill);
        check("illegal", illegal, m_c.ill);
      end
    end else if (illegal) check("illegal_stray", illegal, 0);
    if (wb_valid) begin
      if (q_wb.size() == 0) check("wb_unexpected", wb_valid, 0);
      else begin
        m_w = q_wb.pop_front();
        check("wb_rd", wb_rd, m_w.rd);
        check("wb_data", wb_data, m_w.data);
      end
    end
    if (exc) begin
      if (q_exc.size() == 0) check("exc_unexpected", exc, 0);
      else begin m_e = q_exc.pop_front(); check("exc", exc, m_e); end
    end
    if (mem_req && mem_gnt) begin
      if (q_port.size() == 0) check("memport_unexpected", mem_req, 0);
      else begin
        m_p = q_port.pop_front();
        check("mem_addr", mem_addr, m_p.addr);
        check("mem_we_be", {mem_we, mem_be}, {m_p.we, m_p.be});
        check("mem_wdata", mem_wdata, m_p.wdata);
      end
    end
    if (xif.mem_result_valid) begin
      if (q_mres.size() == 0) check("memres_unexpected", xif.mem_result_valid, 0);
      else begin
        m_r = q_mres.pop_front();
        check("memres_id", xif.mem_result.id, m_r.id);
        check("memres_rdata", xif.mem_result.rdata, m_r.rdata);
        check("memres_err_dbg", {xif.mem_result.err, xif.mem_result.dbg}, 2'b00);
      end
    end
  end

  xid_t exp_id = '0;

  task automatic issue(input logic [31:0] ins, input logic acc, input logic kl);
    int t = 0;
    ecommit_t e;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = ins; rs1 = ins ^ 32'h1111_0000; rs2 = ~ins;
    xif.issue_ready = 1'b1; xif.issue_resp = '{accept: acc, writeback: acc, loadstore: 1'b0, exc: 1'b0};
    @(negedge clk);
    while (!xif.issue_valid && t < 20) begin @(negedge clk); t++; end
    check("issue_valid", xif.issue_valid, 1);
    check("instr_ready", instr_ready, 1);
    check("issue_id", xif.issue_req.id, exp_id);
    check("issue_instr", xif.issue_req.instr, ins);
    check("issue_rs", {xif.issue_req.rs[1], xif.issue_req.rs[0]}, {~ins, ins ^ 32'h1111_0000});
    check("issue_flags", {xif.issue_req.mode, xif.issue_req.rs_valid, xif.issue_req.ecs_valid,
                          xif.issue_req.ecs}, {2'b11, 2'b11, 1'b1, 6'h0});
    e.id = exp_id; e.kill = kl || !acc; e.ill = !acc;
    q_commit.push_back(e);
    exp_id = exp_id + xid_t'(1);
    @(posedge clk); #1;
    instr_valid = 1'b0; xif.issue_ready = 1'b0; kill = kl;
    @(posedge clk); #1;
    kill = 1'b0;
  endtask

  task automatic send_result(input xid_t id, input logic we, input logic [4:0] rd,
                             input logic [31:0] d, input logic ex);
    ewb_t w;
    @(posedge clk); #1;
    xif.result_valid = 1'b1;
    xif.result = '{id: id, data: d, rd: rd, we: we, exc: ex, exccode: ex ? 6'd2 : 6'd0};
    w.rd = rd; w.data = d;
    if (we) q_wb.push_back(w);
    if (ex) q_exc.push_back(1'b1);
    @(posedge clk); #1;
    xif.result_valid = 1'b0;
  endtask

  task automatic mem_access(input xid_t id, input logic [31:0] a, input logic we,
                            input logic [3:0] be, input logic [31:0] wd, input int gd,
                            input logic [31:0] rdat);
    eport_t p;
    emres_t r;
    @(posedge clk); #1;
    xif.mem_valid = 1'b1;
    xif.mem_req = '{id: id, addr: a, we: we, be: be, wdata: wd};
    p.addr = a; p.we = we; p.be = be; p.wdata = wd;
    r.id = id; r.rdata = we ? 32'h0 : rdat;
    q_port.push_back(p); q_mres.push_back(r);
    @(negedge clk); check("mem_ready", xif.mem_ready, 1);
    @(posedge clk); #1;
    xif.mem_valid = 1'b0; xif.mem_req = '0;
    for (int i = 0; i < gd; i++) begin
      @(negedge clk); check("mem_req_hold", mem_req, 1);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = we ? 32'hBAD0_BAD0 : rdat;
    @(negedge clk);
    check("mem_req_drop", mem_req, 0);
    check("memres_early", xif.mem_result_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk); check("memres_latency", xif.mem_result_valid, 1);
    @(posedge clk); #1;
    check("mem_idle_again", xif.mem_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  localparam logic [31:0] FIR = 32'h0000_100B;

  initial begin
    instr_valid = 0; instr = 0; rs1 = 0; rs2 = 0; kill = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    xif.issue_ready = 0; xif.issue_resp = '0;
    xif.mem_valid = 0; xif.mem_req = '0;
    xif.result_valid = 0; xif.result = '0;

    repeat (2) @(negedge clk);
    check("rst_xif_valids", {xif.issue_valid, xif.commit_valid, xif.mem_ready,
                             xif.mem_result_valid, xif.result_ready}, 5'b0);
    check("rst_outputs", {instr_ready, mem_req, wb_valid, illegal, exc, xif.commit.commit_kill}, 6'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {xif.mem_ready, xif.result_ready, xif.issue_valid}, 3'b110);

    // rejected instruction
    issue(32'h0000_0013, 1'b0, 1'b0);
    check("outstanding_rej", dut.r_outstanding, 0);

    // accepted instruction with writeback result
    issue(FIR, 1'b1, 1'b0);
    check("outstanding_1", dut.r_outstanding, 1);
    send_result(4'd1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    check("outstanding_0", dut.r_outstanding, 0);

    // exception result, then a silent result
    issue(FIR, 1'b1, 1'b0);
    send_result(4'd2, 1'b0, 5'd0, 32'h0, 1'b1);
    issue(FIR, 1'b1, 1'b0);
    send_result(4'd3, 1'b0, 5'd7, 32'h55, 1'b0);
    check("outstanding_after_exc", dut.r_outstanding, 0);

    // credit limit
    for (int k = 0; k < 4; k++) issue(FIR + 32'(k << 7), 1'b1, 1'b0);
    check("outstanding_full", dut.r_outstanding, 4);
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = FIR;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("credit_block", xif.issue_valid, 0);
    end
    send_result(4'd4, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk); check("credit_release", xif.issue_valid, 1);
    issue(FIR, 1'b1, 1'b0);
    for (int k = 5; k < 9; k++) send_result(xid_t'(k), 1'b1, 5'(10 + k), 32'hA000_0000 + 32'(k), 1'b0);
    check("outstanding_drained", dut.r_outstanding, 0);

    // kill during commit
    issue(FIR, 1'b1, 1'b1);
    check("outstanding_kill", dut.r_outstanding, 0);

    // id wrap 15 -> 0
    for (int k = 0; k < 8; k++) issue(32'h0000_0013, 1'b0, 1'b0);

    // memory read then write
    mem_access(4'h3, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 2, 32'h1234_5678);
    mem_access(4'h5, 32'h0000_0204, 1'b1, 4'b0011, 32'hCAFE_F00D, 0, 32'h0);

    repeat (3) @(posedge clk);
    check("q_commit_left", q_commit.size(), 0);
    check("q_wb_left", q_wb.size(), 0);
    check("q_exc_left", q_exc.size(), 0);
    check("q_mem_left", q_port.size() + q_mres.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
